mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h8000_0000, the byte address of word 0.
REQ-002 The block SHALL have parameter DEPTH, default 1024, the storage size in 32-bit words.
REQ-003 The block SHALL have parameter LAT, default 2, legal range 1..15, the cycles from request accept to rsp_valid.
REQ-004 One clock and one reset: the block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit, the reset: synchronous and active-high.
REQ-006 The block SHALL have port req_valid, input, 1 bit, request present.
REQ-007 The block SHALL have port req_ready, output, 1 bit, request can be accepted.
REQ-008 The block SHALL have port req_wen, input, 1 bit, 1 = store, 0 = load.
REQ-009 The block SHALL have port req_addr, input, 32 bits, byte address.
REQ-010 The block SHALL have port req_wdata, input, 32 bits, store data, right-aligned.
REQ-011 The block SHALL have ports req_suffix_b and req_suffix_h, input, 1 bit each, byte or halfword access; both 0 = word.
REQ-012 The block SHALL have port req_sext, input, 1 bit, sign-extend load data.
REQ-013 The block SHALL have port rsp_valid, output, 1 bit, response present.
REQ-014 The block SHALL have port rsp_ready, input, 1 bit, the initiator accepts the response.
REQ-015 The block SHALL have port rsp_rdata, output, 32 bits, load data, extended.
REQ-016 The block SHALL have port rsp_err, output, 1 bit, access fault.

Function
REQ-017 The FSM SHALL have three states, IDLE, WAIT and RESP, and exactly one transaction SHALL be outstanding at a time.
REQ-018 req_ready SHALL be 1 only in IDLE.
REQ-019 A request SHALL be accepted on an edge where req_valid and req_ready are both 1, capturing all req_* fields.
REQ-020 Transitions:
- On accept with LAT=1: IDLE -> RESP.
- On accept with LAT>1: IDLE -> WAIT, counter loaded with LAT-1.
- WAIT: counter decrements each cycle.
- WAIT -> RESP on the edge where the counter equals 1.
REQ-021 rsp_valid SHALL rise exactly LAT cycles after the accept edge.
REQ-022 On the edge entering RESP, a store SHALL commit to the array and a load SHALL capture rsp_rdata.
REQ-023 In RESP, rsp_valid=1 and rsp_rdata/rsp_err SHALL hold stable until rsp_ready=1; on that edge RESP -> IDLE.
REQ-024 Maximum throughput SHALL be one transaction per LAT+1 cycles.
REQ-025 Size priority SHALL be suffix_b over suffix_h over word.
REQ-026 Load extraction:
- Byte: lane addr[1:0].
- Halfword: lane addr[1].
- Result zero-extended, or sign-extended when sext=1.
- sext SHALL be ignored for word accesses.
REQ-027 A store SHALL write only the addressed byte lanes, using wdata[7:0], wdata[15:0] or wdata[31:0]; the other lanes SHALL be unchanged.
REQ-028 A fault (rsp_err=1) SHALL be raised when either condition holds:
- address outside [BASE_ADDR, BASE_ADDR+4*DEPTH);
- misalignment: halfword with addr[0]=1, or word with addr[1:0]!=0.
REQ-029 A faulting access SHALL NOT modify the array and SHALL return rsp_rdata=0.
REQ-030 For stores, rsp_rdata SHALL be 0.
REQ-031 The word index SHALL be (addr-BASE_ADDR)>>2, computed with 32-bit unsigned arithmetic; underflow SHALL be detected as out of range, with no wrap-around.
REQ-032 req_valid asserted in WAIT or RESP SHALL be ignored; the initiator holds the request until accepted.

Reset
REQ-033 When rst=1 at an edge, the block SHALL go to IDLE, clear the counter, and drive rsp_valid=0, rsp_err=0, rsp_rdata=0; req_ready SHALL be 0 while rst=1.
REQ-034 A reset in WAIT SHALL drop the pending store uncommitted; a reset in RESP SHALL discard the response.
REQ-035 Array contents SHALL NOT be affected by reset.
REQ-036 A request presented on the edge where rst=1 SHALL NOT be accepted.

Structure
REQ-037 A shared package mem_pkg SHALL hold:
- the state enum {IDLE, WAIT, RESP};
- the size encoding {SZ_B, SZ_H, SZ_W};
- the default BASE_ADDR constant.
REQ-038 Byte-lane extraction/extension and store merge with byte enables SHALL live in one combinational sub-module, mem_lane_align.
REQ-039 The FSM, counter, address check and storage array SHALL reside in mem_responder.

Verification
REQ-040 Word store then load, LAT=2, rsp_ready=1: store 0xDEADBEEF at 0x8000_0010, then load 0x8000_0010 -> rdata=0xDEADBEEF, err=0, rsp_valid exactly 2 cycles after each accept.
REQ-041 Byte lanes: word 0x11223344 at 0x8000_0020, store byte 0xF0 at 0x8000_0021 -> word reads 0x1122F044; load byte 0x8000_0021 with sext=1 -> 0xFFFFFFF0; with sext=0 -> 0x000000F0.
REQ-042 Faults: halfword load at 0x8000_0003 -> err=1, rdata=0; store at 0x7FFF_FFFC -> err=1, array unchanged; store at BASE_ADDR+4*DEPTH -> err=1.
REQ-043 Backpressure: rsp_ready held 0 for 5 cycles -> rsp_valid, rdata and err stable, req_ready=0 throughout; IDLE and req_ready=1 on the cycle after rsp_ready=1.
REQ-044 Reset mid-WAIT, LAT=4: store 0x55 to 0x8000_0040 (previously 0), rst pulsed one cycle after accept -> no rsp_valid; a subsequent load returns 0.
REQ-045 LAT=1 back-to-back: rsp_valid on the cycle after accept; with req_valid held high, one accept every 2 cycles.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder.
//   state_e     : responder FSM states
//   size_e      : access size after suffix decode
//   decode_size : suffix bits -> access size
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_e;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h8000_0000;

    // The byte suffix wins over the halfword suffix; neither set means a full word.
    function automatic size_e decode_size(input logic suffix_b, input logic suffix_h);
        if (suffix_b) begin
            return SZ_B;
        end else if (suffix_h) begin
            return SZ_H;
        end
        return SZ_W;
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between an initiator and the memory responder.
//   req_*  : request channel (valid/ready handshake, store/load fields)
//   rsp_*  : response channel (valid/ready handshake, load data, fault)
// master = initiator side, slave = responder side.
interface mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_suffix_b;
    logic        req_suffix_h;
    logic        req_sext;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_wen, req_addr, req_wdata, req_suffix_b, req_suffix_h, req_sext,
        output rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, req_suffix_b, req_suffix_h, req_sext,
        input  rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/mem_lane_align.sv
// Combinational byte-lane handling for the memory responder.
//   size, offset : access size and byte offset within the word (addr[1:0])
//   sext         : sign-extend sub-word load data
//   rword        : current contents of the addressed word
//   wdata        : right-aligned store data
//   rdata        : extracted and extended load data
//   wword        : rword with the addressed lanes replaced by store data
module mem_lane_align
    import mem_pkg::*;
(
    input  size_e       size,
    input  logic [1:0]  offset,
    input  logic        sext,
    input  logic [31:0] rword,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [31:0] wword
);

    logic [3:0]  be;
    logic [31:0] wlanes;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    always_comb begin
        rbyte  = rword[{offset, 3'b000} +: 8];
        rhalf  = rword[{offset[1], 4'b0000} +: 16];
        be     = 4'b1111;
        wlanes = wdata;
        rdata  = rword;
        wword  = rword;
        case (size)
            SZ_B: begin
                be     = 4'b0001 << offset;
                wlanes = {4{wdata[7:0]}};
                rdata  = {{24{sext & rbyte[7]}}, rbyte};
            end
            SZ_H: begin
                be     = offset[1] ? 4'b1100 : 4'b0011;
                wlanes = {2{wdata[15:0]}};
                rdata  = {{16{sext & rhalf[15]}}, rhalf};
            end
            default: ;
        endcase
        // Store data is replicated across all lanes; byte enables pick the ones that land.
        for (int i = 0; i < 4; i++) begin
            wword[8*i +: 8] = be[i] ? wlanes[8*i +: 8] : rword[8*i +: 8];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder with fixed response latency.
//   clk : clock, all state on rising edge
//   rst : synchronous active-high reset (array contents are kept)
//   bus : request/response channel, slave side
// Parameters: BASE_ADDR (byte address of word 0), DEPTH (words), LAT (1..15 cycles).
module mem_responder
    import mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned LAT       = 2
) (
    input logic            clk,
    input logic            rst,
    mem_responder_if.slave bus
);

    localparam int          IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [32:0] SPAN     = 33'(DEPTH) << 2;
    localparam logic [3:0]  CNT_LOAD = 4'(LAT - 1);

    logic [31:0] mem [DEPTH];

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wen_q, wen_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    size_e       size_q, size_d;
    logic        sext_q, sext_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;

    logic        accept, enter_resp, mem_we;
    logic        in_range, misaligned, fault;
    logic        a_wen, a_sext;
    logic [31:0] a_addr, a_wdata, offs;
    size_e       a_size;
    logic [IW-1:0] idx;
    logic [31:0] rd_word, lane_rdata, lane_wword;

    assign bus.req_ready = (state_q == IDLE) && !rst;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;

    assign accept = bus.req_valid && bus.req_ready;

    // With LAT=1 the access completes on the accept edge itself, so while idle
    // the datapath works straight off the live request.
    always_comb begin
        if (state_q == IDLE) begin
            a_wen   = bus.req_wen;
            a_addr  = bus.req_addr;
            a_wdata = bus.req_wdata;
            a_size  = decode_size(bus.req_suffix_b, bus.req_suffix_h);
            a_sext  = bus.req_sext;
        end else begin
            a_wen   = wen_q;
            a_addr  = addr_q;
            a_wdata = wdata_q;
            a_size  = size_q;
            a_sext  = sext_q;
        end
    end

    // The subtraction wraps below BASE_ADDR; the explicit compare rejects that case.
    assign offs     = a_addr - BASE_ADDR;
    assign in_range = (a_addr >= BASE_ADDR) && ({1'b0, offs} < SPAN);

    always_comb begin
        misaligned = 1'b0;
        case (a_size)
            SZ_H:    misaligned = a_addr[0];
            SZ_W:    misaligned = (a_addr[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
    end

    assign fault   = !in_range || misaligned;
    assign idx     = offs[IW+1:2];
    assign rd_word = mem[idx];

    mem_lane_align u_lane (
        .size   (a_size),
        .offset (a_addr[1:0]),
        .sext   (a_sext),
        .rword  (rd_word),
        .wdata  (a_wdata),
        .rdata  (lane_rdata),
        .wword  (lane_wword)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wen_d       = wen_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        size_d      = size_q;
        sext_d      = sext_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        enter_resp  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    wen_d   = a_wen;
                    addr_d  = a_addr;
                    wdata_d = a_wdata;
                    size_d  = a_size;
                    sext_d  = a_sext;
                    if (LAT == 1) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd1) begin
                    state_d    = RESP;
                    cnt_d      = 4'd0;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (enter_resp) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = fault;
            rsp_rdata_d = (fault || a_wen) ? 32'd0 : lane_rdata;
        end
    end

    assign mem_we = enter_resp && a_wen && !fault && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Captured request fields are only consumed outside IDLE, so they need no reset.
    always_ff @(posedge clk) begin
        wen_q   <= wen_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        size_q  <= size_d;
        sext_q  <= sext_d;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx] <= lane_wword;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder: three instances (LAT=2, 4, 1) share stimulus,
// one is selected at a time and checked against a transaction-level model.
module tb_mem_responder;

    localparam logic [31:0] BASE   = 32'h8000_0000;
    localparam longint      BASE_L = 64'h8000_0000;
    localparam int          DEPTH  = 1024;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int          sel;
    logic        c_valid, c_wen, c_b, c_h, c_sext, c_rready;
    logic [31:0] c_addr, c_wdata;

    mem_responder_if if0 ();
    mem_responder_if if1 ();
    mem_responder_if if2 ();

    assign if0.req_valid = c_valid && (sel == 0);
    assign if1.req_valid = c_valid && (sel == 1);
    assign if2.req_valid = c_valid && (sel == 2);
    assign if0.req_wen = c_wen;   assign if1.req_wen = c_wen;   assign if2.req_wen = c_wen;
    assign if0.req_addr = c_addr; assign if1.req_addr = c_addr; assign if2.req_addr = c_addr;
    assign if0.req_wdata = c_wdata; assign if1.req_wdata = c_wdata; assign if2.req_wdata = c_wdata;
    assign if0.req_suffix_b = c_b; assign if1.req_suffix_b = c_b; assign if2.req_suffix_b = c_b;
    assign if0.req_suffix_h = c_h; assign if1.req_suffix_h = c_h; assign if2.req_suffix_h = c_h;
    assign if0.req_sext = c_sext; assign if1.req_sext = c_sext; assign if2.req_sext = c_sext;
    assign if0.rsp_ready = c_rready; assign if1.rsp_ready = c_rready; assign if2.rsp_ready = c_rready;

    mem_responder #(.LAT(2)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    mem_responder #(.LAT(4)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    mem_responder #(.LAT(1)) dut2 (.clk(clk), .rst(rst), .bus(if2));

    logic        d_ready, d_valid, d_err;
    logic [31:0] d_rdata;
    always_comb begin
        case (sel)
            0: begin d_ready = if0.req_ready; d_valid = if0.rsp_valid; d_err = if0.rsp_err; d_rdata = if0.rsp_rdata; end
            1: begin d_ready = if1.req_ready; d_valid = if1.rsp_valid; d_err = if1.rsp_err; d_rdata = if1.rsp_rdata; end
            default: begin d_ready = if2.req_ready; d_valid = if2.rsp_valid; d_err = if2.rsp_err; d_rdata = if2.rsp_rdata; end
        endcase
    end

    function automatic int lat_of(input int s);
        return (s == 0) ? 2 : ((s == 1) ? 4 : 1);
    endfunction

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t, dut=%0d)", name, act, exp, $time, sel);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] mm [3][DEPTH];
    bit          mk [3][DEPTH];
    bit          chk_en = 1'b0;
    bit          m_busy = 1'b0;
    longint      m_edge = 0;
    longint      m_resp_edge = 0;
    bit          m_wen, m_b, m_h, m_sext;
    logic [31:0] m_addr, m_wdata;
    logic [31:0] m_rdata = 32'd0;
    bit          m_err = 1'b0;
    bit          m_dknown = 1'b1;

    task automatic model_resp(input int s);
        longint      a;
        longint      widx;
        int          size;
        int          sh;
        logic [31:0] w, v, lowmask, mask;
        a    = longint'(m_addr);
        size = m_b ? 1 : (m_h ? 2 : 4);
        m_err    = (a < BASE_L) || (a >= BASE_L + 4 * DEPTH) || ((a % size) != 0);
        m_rdata  = 32'd0;
        m_dknown = 1'b1;
        if (!m_err) begin
            widx    = (a - BASE_L) / 4;
            sh      = int'(8 * (a % 4));
            lowmask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
            w       = mm[s][widx];
            if (m_wen) begin
                mask          = lowmask << sh;
                mm[s][widx]   = (w & ~mask) | ((m_wdata << sh) & mask);
                if (size == 4) mk[s][widx] = 1'b1;
            end else begin
                m_dknown = mk[s][widx];
                v = (w >> sh) & lowmask;
                if (m_sext && size < 4 && v[8*size-1]) v = v | ~lowmask;
                m_rdata = v;
            end
        end
    endtask

    always @(negedge clk) begin
        bit ev;
        if (chk_en) begin
            ev = m_busy && (m_edge >= m_resp_edge);
            check("req_ready", d_ready, !m_busy && !rst);
            check("rsp_valid", d_valid, ev);
            if (ev) begin
                check("rsp_err", d_err, m_err);
                if (m_dknown) check("rsp_rdata", d_rdata, m_rdata);
            end
            // advance to the coming edge
            if (rst) begin
                m_busy = 1'b0;
            end else if (m_busy && ev && c_rready) begin
                m_busy = 1'b0;
            end else if (!m_busy && c_valid) begin
                m_busy      = 1'b1;
                m_wen       = c_wen;
                m_addr      = c_addr;
                m_wdata     = c_wdata;
                m_b         = c_b;
                m_h         = c_h;
                m_sext      = c_sext;
                m_resp_edge = m_edge + lat_of(sel);
            end
            if (!rst && m_busy && (m_resp_edge == m_edge + 1)) model_resp(sel);
            m_edge++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_req(input bit wen, input logic [31:0] addr, input logic [31:0] wdata,
                           input bit b, input bit h, input bit sext);
        c_wen = wen; c_addr = addr; c_wdata = wdata; c_b = b; c_h = h; c_sext = sext;
    endtask

    task automatic txn(input bit wen, input logic [31:0] addr, input logic [31:0] wdata,
                       input bit b, input bit h, input bit sext, input int hold,
                       output logic [31:0] rdata, output logic err);
        int k;
        @(posedge clk); #1;
        set_req(wen, addr, wdata, b, h, sext);
        c_valid  = 1'b1;
        c_rready = (hold == 0);
        k = 0;
        @(negedge clk);
        while (!d_ready && k < 50) begin @(negedge clk); k++; end
        if (!d_ready) begin
            check("accept_wait", d_ready, 1);
            c_valid = 1'b0; rdata = 32'd0; err = 1'b0;
            return;
        end
        @(posedge clk); #1;
        c_valid = 1'b0;
        k = 0;
        do begin @(negedge clk); k++; end while (!d_valid && k < 40);
        check("latency", k, lat_of(sel));
        rdata = d_rdata;
        err   = d_err;
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                check("hold_valid", d_valid, 1);
                check("hold_rdata", d_rdata, rdata);
                check("hold_err", d_err, err);
                check("hold_req_ready", d_ready, 0);
            end
            c_rready = 1'b1;
        end
        @(posedge clk); #1;
        check("ready_after_rsp", d_ready, 1);
        c_rready = 1'b0;
    endtask

    task automatic random_phase(input int n);
        logic [31:0] rd, addr;
        logic        er;
        int          r;
        bit          b, h;
        for (int w = 0; w < 16; w++) txn(1, BASE + 32'(4 * w), $urandom, 0, 0, 0, 0, rd, er);
        for (int i = 0; i < n; i++) begin
            r = $urandom_range(0, 9);
            case (r)
                0: addr = BASE - 32'(4 * $urandom_range(1, 4));
                1: addr = BASE + 32'h1000 + 32'($urandom_range(0, 7));
                2: addr = $urandom;
                default: addr = BASE + 32'($urandom_range(0, 63));
            endcase
            b = ($urandom_range(0, 2) == 0);
            h = ($urandom_range(0, 1) == 0);
            txn($urandom_range(0, 1) == 1, addr, $urandom, b, h, $urandom_range(0, 1) == 1,
                $urandom_range(0, 2), rd, er);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          k, acc;
        bit          seen;

        sel = 0; rst = 1'b1;
        c_valid = 1'b0; c_rready = 1'b0;
        set_req(0, BASE, 32'd0, 0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_req_ready", d_ready, 0);
        check("reset_rsp_valid", d_valid, 0);
        check("reset_rsp_rdata", d_rdata, 0);
        check("reset_rsp_err", d_err, 0);
        chk_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;

        // ---- LAT=2 directed ----
        txn(1, 32'h8000_0010, 32'hDEAD_BEEF, 0, 0, 0, 0, rd, er);
        check("store_word_err", er, 0);
        check("store_word_rdata", rd, 0);
        txn(0, 32'h8000_0010, 0, 0, 0, 0, 0, rd, er);
        check("load_word", rd, 32'hDEAD_BEEF);
        check("load_word_err", er, 0);

        txn(1, 32'h8000_0020, 32'h1122_3344, 0, 0, 0, 0, rd, er);
        txn(1, 32'h8000_0021, 32'h0000_00F0, 1, 0, 0, 0, rd, er);
        txn(0, 32'h8000_0020, 0, 0, 0, 1, 0, rd, er);
        check("merged_word", rd, 32'h1122_F044);
        txn(0, 32'h8000_0021, 0, 1, 0, 1, 0, rd, er);
        check("byte_sext", rd, 32'hFFFF_FFF0);
        txn(0, 32'h8000_0021, 0, 1, 0, 0, 0, rd, er);
        check("byte_zext", rd, 32'h0000_00F0);
        txn(0, 32'h8000_0020, 0, 0, 1, 1, 0, rd, er);
        check("half_lo_sext", rd, 32'hFFFF_F044);
        txn(0, 32'h8000_0022, 0, 1, 1, 0, 0, rd, er);
        check("b_over_h", rd, 32'h0000_0022);

        txn(0, 32'h8000_0003, 0, 0, 1, 0, 0, rd, er);
        check("half_misalign_err", er, 1);
        check("half_misalign_rdata", rd, 0);
        txn(0, 32'h8000_0012, 0, 0, 0, 0, 0, rd, er);
        check("word_misalign_err", er, 1);

        txn(1, 32'h8000_0FFC, 32'hCAFE_F00D, 0, 0, 0, 0, rd, er);
        check("last_word_err", er, 0);
        txn(1, 32'h7FFF_FFFC, 32'h1234_5678, 0, 0, 0, 0, rd, er);
        check("underflow_err", er, 1);
        txn(0, 32'h8000_0FFC, 0, 0, 0, 0, 0, rd, er);
        check("underflow_no_write", rd, 32'hCAFE_F00D);
        txn(1, 32'h8000_0000, 32'hA5A5_A5A5, 0, 0, 0, 0, rd, er);
        txn(1, 32'h8000_1000, 32'h0BAD_0BAD, 0, 0, 0, 0, rd, er);
        check("overflow_err", er, 1);
        txn(0, 32'h8000_0000, 0, 0, 0, 0, 0, rd, er);
        check("overflow_no_write", rd, 32'hA5A5_A5A5);

        txn(0, 32'h8000_0010, 0, 0, 0, 0, 5, rd, er);
        check("backpressure_rdata", rd, 32'hDEAD_BEEF);

        // reset while a load response is being held
        @(posedge clk); #1;
        set_req(0, 32'h8000_0010, 0, 0, 0, 0);
        c_valid = 1'b1; c_rready = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        c_valid = 1'b0;
        k = 0;
        do begin @(negedge clk); k++; end while (!d_valid && k < 10);
        check("resp_before_rst", d_rdata, 32'hDEAD_BEEF);
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        check("rst_resp_valid", d_valid, 0);
        check("rst_resp_rdata", d_rdata, 0);
        check("rst_resp_err", d_err, 0);

        // ---- LAT=4: reset in WAIT drops a store ----
        @(posedge clk); #1; sel = 1;
        txn(1, 32'h8000_0040, 32'd0, 0, 0, 0, 0, rd, er);
        @(posedge clk); #1;
        set_req(1, 32'h8000_0040, 32'h0000_0055, 0, 0, 0);
        c_valid = 1'b1; c_rready = 1'b1;
        @(negedge clk);
        check("rstwait_ready", d_ready, 1);
        @(posedge clk); #1;
        c_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin @(negedge clk); if (d_valid) seen = 1'b1; end
        check("rstwait_no_rsp", seen, 0);
        c_rready = 1'b0;
        txn(0, 32'h8000_0040, 0, 0, 0, 0, 0, rd, er);
        check("rstwait_dropped", rd, 0);

        // ---- LAT=1: back-to-back ----
        @(posedge clk); #1; sel = 2;
        txn(1, 32'h8000_0010, 32'h0F0F_1234, 0, 0, 0, 0, rd, er);
        @(posedge clk); #1;
        set_req(0, 32'h8000_0010, 0, 0, 0, 0);
        c_valid = 1'b1; c_rready = 1'b1;
        acc = 0;
        for (int i = 0; i < 10; i++) begin @(negedge clk); if (d_ready && c_valid) acc++; end
        check("b2b_accepts", acc, 5);
        @(posedge clk); #1;
        c_valid = 1'b0; c_rready = 1'b0;

        // ---- randomized traffic on every instance ----
        for (int s = 0; s < 3; s++) begin
            @(posedge clk); #1; sel = s;
            random_phase(40);
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
